// File: rtl/crossbar_pkg.sv
// crossbar_pkg: default sizes and the {data, src} response-entry layout shared by both crossbars
package crossbar_pkg;
  localparam int N_SIZE_DEF = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int FIFO_SIZE_DEF = 2;
  function automatic int rsp_entry_w(input int data_w, input int src_w);
    return data_w + src_w;
  endfunction
endpackage

// File: rtl/rsp_fifo.sv
// rsp_fifo: synchronous FIFO; pushes into a full FIFO are refused even when it pops in the same cycle
module rsp_fifo #(
  parameter int W = 34,
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign empty = r_cnt == '0;
  assign full = r_cnt == CW'(DEPTH);
  assign count = r_cnt;
  assign head = r_mem[r_rp];
  assign w_push = push && !full;
  assign w_pop = pop && !empty;
  always_ff @(posedge CLK) if (w_push) r_mem[r_wp] <= wdata;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp == PW'(DEPTH-1) ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp == PW'(DEPTH-1) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/response_crossbar.sv
// response_crossbar: routes per-destination responses back to their source ports via per-source round-robin
module response_crossbar
  import crossbar_pkg::*;
#(
  parameter int N_SIZE = N_SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_SIZE = FIFO_SIZE_DEF,
  parameter int SRC_BITS = $clog2(N_SIZE)
) (
  input  logic                                CLK,
  input  logic                                nRST,
  input  logic [N_SIZE-1:0]                   rsp_valid,
  input  logic [N_SIZE-1:0][DATA_WIDTH-1:0]   rsp_data,
  input  logic [N_SIZE-1:0][SRC_BITS-1:0]     rsp_src,
  output logic [N_SIZE-1:0]                   rsp_ready,
  output logic [N_SIZE-1:0]                   out_valid,
  output logic [N_SIZE-1:0][DATA_WIDTH-1:0]   out_data,
  input  logic [N_SIZE-1:0]                   out_ready,
  output logic                                stall
);
  localparam int EW = rsp_entry_w(DATA_WIDTH, SRC_BITS);
  localparam int CW = $clog2(FIFO_SIZE+1);
  logic [N_SIZE-1:0][EW-1:0] w_head;
  logic [N_SIZE-1:0] w_empty, w_full, w_pop, w_free, w_grant;
  logic [CW-1:0] w_count [N_SIZE];
  logic [SRC_BITS-1:0] w_gd [N_SIZE];
  logic [SRC_BITS-1:0] r_ptr [N_SIZE];
  logic [N_SIZE-1:0] r_out_valid;
  logic [N_SIZE-1:0][DATA_WIDTH-1:0] r_out_data;
  assign out_valid = r_out_valid;
  assign out_data = r_out_data;
  assign w_free = ~r_out_valid | out_ready;
  assign stall = |w_full;
  for (genvar d = 0; d < N_SIZE; d++) begin : g_fifo
    rsp_fifo #(.W(EW), .DEPTH(FIFO_SIZE)) u_fifo (
      .CLK   (CLK),
      .nRST  (nRST),
      .push  (rsp_valid[d]),
      .pop   (w_pop[d]),
      .wdata ({rsp_data[d], rsp_src[d]}),
      .head  (w_head[d]),
      .empty (w_empty[d]),
      .full  (w_full[d]),
      .count (w_count[d])
    );
    assign rsp_ready[d] = w_count[d] != CW'(FIFO_SIZE);
  end
  for (genvar s = 0; s < N_SIZE; s++) begin : g_arb
    logic v;
    logic [SRC_BITS-1:0] sel, i;
    // scan backwards so the candidate nearest rr_ptr is the last one written
    always_comb begin
      v = 1'b0;
      sel = r_ptr[s];
      i = '0;
      for (int k = N_SIZE - 1; k >= 0; k--) begin
        i = r_ptr[s] + SRC_BITS'(k);
        if (!w_empty[i] && w_head[i][SRC_BITS-1:0] == SRC_BITS'(s)) begin
          v = 1'b1;
          sel = i;
        end
      end
    end
    assign w_grant[s] = v && w_free[s];
    assign w_gd[s] = sel;
  end
  always_comb begin
    w_pop = '0;
    for (int s = 0; s < N_SIZE; s++) if (w_grant[s]) w_pop[w_gd[s]] = 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_out_valid <= '0;
      r_out_data <= '0;
      for (int s = 0; s < N_SIZE; s++) r_ptr[s] <= '0;
    end else begin
      for (int s = 0; s < N_SIZE; s++) begin
        if (w_free[s]) r_out_valid[s] <= w_grant[s];
        if (w_grant[s]) begin
          r_out_data[s] <= w_head[w_gd[s]][EW-1:SRC_BITS];
          r_ptr[s] <= w_gd[s] + 1'b1;
        end
      end
    end
  end
endmodule
